packet_parser: RTL and testbench

- Receive-side counterpart of the packet builder. On `pp_start` it reads a built packet byte by byte from incoming memory and checks the SOP byte.
- It decodes the header, re-computes CRC-8 over the payload and compares it with the packet's CRC byte.
- It packs the payload contiguously into 32-bit words of outgoing memory, then reports status and raises `pp_irq`.
- Sits beside the packet builder on the same memory fabric and is driven by the same register block style.

---
 rtl/packet_parser.sv | 234 +++++++++++++++++++++++
 tb/tb_packet_parser.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_parser.sv
// -----------------------------------------------------------------------------
// packet_parser
//   Receive-side packet parser. On pp_start it fetches a packet byte by byte
//   from inmem, checks the SOP byte and decodes the header {type, cnt}.
//   It recomputes CRC-8 over the payload and compares it with the trailing
//   CRC byte. The payload is packed contiguously into 32-bit words of outmem.
//   Completion is signalled with a one-cycle pp_irq pulse.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   pp_start        one-cycle start pulse (ignored unless idle)
//   pp_addr_in      byte address of the SOP byte in inmem (any alignment)
//   pp_addr_out     payload destination in outmem (bits [1:0] ignored)
//   pp_sop_val      expected SOP byte
//   inmem_addr      byte read address; data returns one cycle later
//   inmem_data_i    read word; the byte lane comes from the request addr[1:0]
//   outmem_addr     word-aligned write address
//   outmem_data_o   write data; payload byte j sits in lane j%4
//   outmem_we       per-lane byte write enable (0 = no write)
//   pp_busy         transfer in progress (through the pp_irq cycle)
//   pp_irq          one-cycle completion pulse
//   pp_pkt_type     header[7:4]
//   pp_byte_cnt     header[3:0]; payload length is pp_byte_cnt + 1
//   pp_crc_calc     CRC-8 computed over the payload
//   pp_sop_err      SOP byte mismatch
//   pp_crc_err      CRC byte mismatch
// -----------------------------------------------------------------------------
module packet_parser #(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [7:0]  CRC_POLY = 8'h07
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pp_start,
  input  logic [ADDR_W-1:0] pp_addr_in,
  input  logic [ADDR_W-1:0] pp_addr_out,
  input  logic [7:0]        pp_sop_val,
  output logic [ADDR_W-1:0] inmem_addr,
  input  logic [31:0]       inmem_data_i,
  output logic [ADDR_W-1:0] outmem_addr,
  output logic [31:0]       outmem_data_o,
  output logic [3:0]        outmem_we,
  output logic              pp_busy,
  output logic              pp_irq,
  output logic [3:0]        pp_pkt_type,
  output logic [3:0]        pp_byte_cnt,
  output logic [7:0]        pp_crc_calc,
  output logic              pp_sop_err,
  output logic              pp_crc_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_SOP  = 3'd1,
    RD_HDR  = 3'd2,
    RD_DATA = 3'd3,
    RD_CRC  = 3'd4,
    DONE    = 3'd5
  } state_t;

  // CRC-8, MSB first, no reflection: fold one byte into the running CRC.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ CRC_POLY;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

  state_t            r_state;
  logic              r_sop_wait;   // RD_SOP first cycle: SOP data not back yet
  logic [1:0]        r_lane;       // addr[1:0] of the request whose data is arriving now
  logic [ADDR_W-1:0] r_end_addr;   // address of the CRC byte (last read)
  logic [7:0]        r_sop_val;
  logic [ADDR_W-1:0] r_out_addr;   // next outmem word address
  logic [7:0]        r_crc;
  logic [3:0]        r_idx;        // payload byte index of the arriving byte
  logic [31:0]       r_buf;
  logic [3:0]        r_mask;

  logic [7:0]        w_byte;
  logic [7:0]        w_crc_n;
  logic [31:0]       w_buf_n;
  logic [3:0]        w_mask_n;
  logic              w_last;
  logic              w_flush;
  logic [ADDR_W-1:0] w_next_addr;

  // Byte extraction, CRC step and pack-buffer merge for the arriving byte.
  always_comb begin
    w_byte   = 8'h00;
    w_buf_n  = r_buf;
    w_mask_n = r_mask;
    case (r_lane)
      2'd0:    w_byte = inmem_data_i[7:0];
      2'd1:    w_byte = inmem_data_i[15:8];
      2'd2:    w_byte = inmem_data_i[23:16];
      2'd3:    w_byte = inmem_data_i[31:24];
      default: w_byte = 8'h00;
    endcase
    case (r_idx[1:0])
      2'd0:    begin w_buf_n[7:0]   = w_byte; w_mask_n = r_mask | 4'b0001; end
      2'd1:    begin w_buf_n[15:8]  = w_byte; w_mask_n = r_mask | 4'b0010; end
      2'd2:    begin w_buf_n[23:16] = w_byte; w_mask_n = r_mask | 4'b0100; end
      2'd3:    begin w_buf_n[31:24] = w_byte; w_mask_n = r_mask | 4'b1000; end
      default: begin w_buf_n = r_buf; w_mask_n = r_mask; end
    endcase
    w_crc_n     = crc8_update(r_crc, w_byte);
    w_last      = (r_idx == pp_byte_cnt);
    if ((r_idx[1:0] == 2'd3) || w_last) begin
      w_flush = 1'b1;
    end else begin
      w_flush = 1'b0;
    end
    w_next_addr = inmem_addr + ADDR_W'(1'b1);
  end

  // Parser FSM: read sequencing, checks, packing and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_sop_wait    <= 1'b0;
      r_lane        <= 2'd0;
      r_end_addr    <= '0;
      r_sop_val     <= 8'h00;
      r_out_addr    <= '0;
      r_crc         <= 8'h00;
      r_idx         <= 4'd0;
      r_buf         <= 32'h0000_0000;
      r_mask        <= 4'd0;
      inmem_addr    <= '0;
      outmem_addr   <= '0;
      outmem_data_o <= 32'h0000_0000;
      outmem_we     <= 4'd0;
      pp_busy       <= 1'b0;
      pp_irq        <= 1'b0;
      pp_pkt_type   <= 4'd0;
      pp_byte_cnt   <= 4'd0;
      pp_crc_calc   <= 8'h00;
      pp_sop_err    <= 1'b0;
      pp_crc_err    <= 1'b0;
    end else begin
      r_lane    <= inmem_addr[1:0];
      outmem_we <= 4'd0;
      pp_irq    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (pp_start) begin
            r_state     <= RD_SOP;
            r_sop_wait  <= 1'b1;
            pp_busy     <= 1'b1;
            inmem_addr  <= pp_addr_in;
            r_sop_val   <= pp_sop_val;
            r_out_addr  <= pp_addr_out & ~ADDR_W'(2'b11);
            r_crc       <= 8'h00;
            r_idx       <= 4'd0;
            r_buf       <= 32'h0000_0000;
            r_mask      <= 4'd0;
            pp_pkt_type <= 4'd0;
            pp_byte_cnt <= 4'd0;
            pp_crc_calc <= 8'h00;
            pp_sop_err  <= 1'b0;
            pp_crc_err  <= 1'b0;
          end
        end
        RD_SOP: begin
          if (r_sop_wait) begin
            r_sop_wait <= 1'b0;
            inmem_addr <= w_next_addr;           // header
          end else if (w_byte != r_sop_val) begin
            pp_sop_err <= 1'b1;
            pp_irq     <= 1'b1;
            r_state    <= DONE;
          end else begin
            // Payload byte 0 always exists, so it can be requested before
            // the header is decoded.
            inmem_addr <= w_next_addr;
            r_state    <= RD_HDR;
          end
        end
        RD_HDR: begin
          pp_pkt_type <= w_byte[7:4];
          pp_byte_cnt <= w_byte[3:0];
          // inmem_addr holds payload 0 (SOP+2); the CRC byte is at SOP+cnt+3.
          r_end_addr  <= inmem_addr + ADDR_W'(w_byte[3:0]) + ADDR_W'(1'b1);
          inmem_addr  <= w_next_addr;
          r_idx       <= 4'd0;
          r_state     <= RD_DATA;
        end
        RD_DATA: begin
          r_crc <= w_crc_n;
          r_idx <= r_idx + 4'd1;
          if (inmem_addr != r_end_addr) begin
            inmem_addr <= w_next_addr;
          end
          if (w_flush) begin
            outmem_we     <= w_mask_n;
            outmem_data_o <= w_buf_n;
            outmem_addr   <= r_out_addr;
            r_out_addr    <= r_out_addr + ADDR_W'(3'd4);
            r_buf         <= 32'h0000_0000;
            r_mask        <= 4'd0;
          end else begin
            r_buf  <= w_buf_n;
            r_mask <= w_mask_n;
          end
          if (w_last) begin
            pp_crc_calc <= w_crc_n;
            r_state     <= RD_CRC;
          end
        end
        RD_CRC: begin
          pp_crc_err <= (w_byte != pp_crc_calc);
          pp_irq     <= 1'b1;
          r_state    <= DONE;
        end
        DONE: begin
          pp_busy <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          pp_busy <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_packet_parser.sv
// Scoreboard bench for packet_parser: stimulus pushes expected outmem writes
// and completion status into queues; a monitor pops them as the DUT presents
// writes (outmem_we != 0) and completions (pp_irq).
module tb_packet_parser;

  logic        clk = 1'b0;
  logic        reset;
  logic        pp_start;
  logic [31:0] pp_addr_in;
  logic [31:0] pp_addr_out;
  logic [7:0]  pp_sop_val;
  logic [31:0] inmem_addr;
  logic [31:0] inmem_data_i;
  logic [31:0] outmem_addr;
  logic [31:0] outmem_data_o;
  logic [3:0]  outmem_we;
  logic        pp_busy;
  logic        pp_irq;
  logic [3:0]  pp_pkt_type;
  logic [3:0]  pp_byte_cnt;
  logic [7:0]  pp_crc_calc;
  logic        pp_sop_err;
  logic        pp_crc_err;

  packet_parser #(.ADDR_W(32), .CRC_POLY(8'h07)) dut (
    .clk(clk), .reset(reset), .pp_start(pp_start),
    .pp_addr_in(pp_addr_in), .pp_addr_out(pp_addr_out), .pp_sop_val(pp_sop_val),
    .inmem_addr(inmem_addr), .inmem_data_i(inmem_data_i),
    .outmem_addr(outmem_addr), .outmem_data_o(outmem_data_o), .outmem_we(outmem_we),
    .pp_busy(pp_busy), .pp_irq(pp_irq), .pp_pkt_type(pp_pkt_type),
    .pp_byte_cnt(pp_byte_cnt), .pp_crc_calc(pp_crc_calc),
    .pp_sop_err(pp_sop_err), .pp_crc_err(pp_crc_err)
  );

  always #5 clk = ~clk;

  // Byte-addressed input memory with one-cycle read latency.
  logic [7:0] mem [0:1023];
  always @(posedge clk) begin
    inmem_data_i <= {mem[{inmem_addr[9:2], 2'b11}], mem[{inmem_addr[9:2], 2'b10}],
                     mem[{inmem_addr[9:2], 2'b01}], mem[{inmem_addr[9:2], 2'b00}]};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] data;
  } wr_t;
  typedef struct {
    int          ncyc;
    logic [3:0]  typ;
    logic [3:0]  cnt;
    logic [7:0]  crc;
    logic        sop_err;
    logic        crc_err;
  } st_t;

  wr_t        wq[$];
  st_t        sq[$];
  logic [7:0] pl[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         start_cyc = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
    wr_t e;
    e.addr = a; e.we = we; e.data = d;
    wq.push_back(e);
  endtask

  task automatic exp_st(input int n, input logic [3:0] t, input logic [3:0] c,
                        input logic [7:0] crc, input logic se, input logic ce);
    st_t e;
    e.ncyc = n; e.typ = t; e.cnt = c; e.crc = crc; e.sop_err = se; e.crc_err = ce;
    sq.push_back(e);
  endtask

  // Packet image at a: SOP, header, payload from pl, CRC.
  task automatic load(input logic [31:0] a, input logic [7:0] sop, input logic [7:0] hdr,
                      input logic [7:0] crc);
    logic [31:0] p;
    p = a;
    mem[p[9:0]] = sop;                 p = p + 32'd1;
    mem[p[9:0]] = hdr;                 p = p + 32'd1;
    foreach (pl[i]) begin mem[p[9:0]] = pl[i]; p = p + 32'd1; end
    mem[p[9:0]] = crc;
  endtask

  // Start pulse sampled at the next posedge (cycle 0); returns in cycle 1
  // with the address inputs scrambled.
  task automatic do_start(input logic [31:0] ai, input logic [31:0] ao, input logic [7:0] sv);
    @(negedge clk);
    pp_addr_in = ai; pp_addr_out = ao; pp_sop_val = sv; pp_start = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clk);
    pp_start = 1'b0; pp_addr_in = 32'hFFFF_FFF0; pp_addr_out = 32'hFFFF_FF00; pp_sop_val = 8'hEE;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sq.size() == 0) break;
    end
    chk("completion_pending", 128'(sq.size()), 128'd0);
    chk("writes_pending", 128'(wq.size()), 128'd0);
    sq.delete();
    wq.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic monitor();
    wr_t         w;
    st_t         s;
    logic [31:0] m;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (outmem_we != 4'd0) begin
          if (wq.size() == 0) begin
            chk("unexpected_write", 128'(outmem_we), 128'd0);
          end else begin
            w = wq.pop_front();
            m = {{8{w.we[3]}}, {8{w.we[2]}}, {8{w.we[1]}}, {8{w.we[0]}}};
            chk("wr_addr", 128'(outmem_addr), 128'(w.addr));
            chk("wr_we", 128'(outmem_we), 128'(w.we));
            chk("wr_data", 128'(outmem_data_o & m), 128'(w.data));
          end
        end
        if (pp_irq) begin
          if (sq.size() == 0) begin
            chk("unexpected_irq", 128'(pp_irq), 128'd0);
          end else begin
            s = sq.pop_front();
            chk("irq_cycle", 128'(cyc - start_cyc + 1), 128'(s.ncyc));
            chk("busy_at_irq", 128'(pp_busy), 128'd1);
            chk("pkt_type", 128'(pp_pkt_type), 128'(s.typ));
            chk("byte_cnt", 128'(pp_byte_cnt), 128'(s.cnt));
            chk("crc_calc", 128'(pp_crc_calc), 128'(s.crc));
            chk("sop_err", 128'(pp_sop_err), 128'(s.sop_err));
            chk("crc_err", 128'(pp_crc_err), 128'(s.crc_err));
          end
        end
      end
    end
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({inmem_addr, outmem_addr, outmem_data_o, outmem_we, pp_busy, pp_irq,
                 pp_pkt_type, pp_byte_cnt, pp_crc_calc, pp_sop_err, pp_crc_err});
  endfunction

  task automatic stimulus();
    // 1: single-byte payload, good CRC
    pl = '{8'h01};
    load(32'h10, 8'h55, 8'h10, 8'h07);
    exp_wr(32'h200, 4'b0001, 32'h0000_0001);
    exp_st(6, 4'd1, 4'd0, 8'h07, 1'b0, 1'b0);
    do_start(32'h10, 32'h200, 8'h55);
    wait_done();

    // 2: same packet, bad CRC byte; status holds after completion
    load(32'h10, 8'h55, 8'h10, 8'h08);
    exp_wr(32'h200, 4'b0001, 32'h0000_0001);
    exp_st(6, 4'd1, 4'd0, 8'h07, 1'b0, 1'b1);
    do_start(32'h10, 32'h200, 8'h55);
    wait_done();
    repeat (3) @(negedge clk);
    chk("crc_err_hold", 128'(pp_crc_err), 128'd1);

    // 3: four-byte payload, full word
    pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    load(32'h20, 8'h55, 8'h23, 8'h69);
    exp_wr(32'h100, 4'hF, 32'hDDCC_BBAA);
    exp_st(9, 4'd2, 4'd3, 8'h69, 1'b0, 1'b0);
    do_start(32'h20, 32'h100, 8'h55);
    wait_done();

    // 4: six bytes from unaligned 0x43, out address low bits ignored
    pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    load(32'h43, 8'h55, 8'h05, 8'hD1);
    exp_wr(32'h300, 4'hF, 32'h4433_2211);
    exp_wr(32'h304, 4'h3, 32'h0000_6655);
    exp_st(11, 4'd0, 4'd5, 8'hD1, 1'b0, 1'b0);
    do_start(32'h43, 32'h302, 8'h55);
    wait_done();

    // 5: SOP mismatch, previous status cleared, no writes
    pl = '{8'h01};
    load(32'h60, 8'h00, 8'h10, 8'h07);
    exp_st(3, 4'd0, 4'd0, 8'h00, 1'b1, 1'b0);
    do_start(32'h60, 32'h200, 8'h55);
    wait_done();

    // 6: 16-byte packet, start during busy, reset mid-transfer
    pl.delete();
    for (int i = 0; i < 16; i++) pl.push_back(8'(i + 1));
    load(32'h80, 8'h55, 8'h2F, 8'h00);
    do_start(32'h80, 32'h400, 8'h55);
    repeat (3) @(negedge clk);                 // cycle 4
    pp_addr_in = 32'h10; pp_addr_out = 32'h200; pp_sop_val = 8'h55; pp_start = 1'b1;
    @(negedge clk);                            // cycle 5
    pp_start = 1'b0;
    chk("busy_start_ignored_addr", 128'(inmem_addr), 128'h84);
    chk("busy_start_ignored_busy", 128'(pp_busy), 128'd1);
    @(negedge clk);                            // cycle 6
    reset = 1'b1;
    @(negedge clk);                            // cycle 7
    reset = 1'b0;
    chk("mid_reset_outputs", all_outs(), 128'd0);
    repeat (25) @(negedge clk);
    chk("idle_after_reset", 128'(pp_busy), 128'd0);

    // 7: fresh start after reset
    pl = '{8'h01};
    load(32'h10, 8'h55, 8'h10, 8'h07);
    exp_wr(32'h200, 4'b0001, 32'h0000_0001);
    exp_st(6, 4'd1, 4'd0, 8'h07, 1'b0, 1'b0);
    do_start(32'h10, 32'h200, 8'h55);
    wait_done();
  endtask

  initial begin
    reset = 1'b1; pp_start = 1'b0;
    pp_addr_in = 32'h0; pp_addr_out = 32'h0; pp_sop_val = 8'h00;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_outputs", all_outs(), 128'd0);
    fork
      monitor();
      stimulus();
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
